// File: rtl/strided_conv_layer_pkg.sv
// Shared definitions for the strided window reduction layer.
// Reduction modes, width helper and the inter-stage flag bundle.
package strided_conv_layer_pkg;

    localparam int MODE_SUM = 0;
    localparam int MODE_MAX = 1;

    typedef struct packed {
        logic v;
        logic last;
    } stage_t;

    function automatic int clog2(input int value);
        int  r;
        longint x;
        r = 0;
        x = 1;
        while (x < longint'(value)) begin
            x = x << 1;
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/line_buffer.sv
// One image row of pixel delay, advanced only on shift_en.
// Contents are never reset; the window logic masks stale data.
module line_buffer #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 64
) (
    input  logic             clk,
    input  logic             shift_en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (shift_en) begin
            mem[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                mem[i] <= mem[i-1];
            end
        end
    end

    assign dout = mem[DEPTH-1];

endmodule

// File: rtl/strided_conv_layer.sv
// Strided FILTER_SIZE x FILTER_SIZE window sum/max over a raster stream.
// Accept edge -> reduce edge -> saturate/output edge.
module strided_conv_layer
    import strided_conv_layer_pkg::*;
#(
    parameter int D_WIDTH     = 8,
    parameter int Q_WIDTH     = 16,
    parameter int D_CHANNELS  = 2,
    parameter int Q_CHANNELS  = 3,
    parameter int FILTER_SIZE = 2,
    parameter int IMAGE_SIZE  = 64,
    parameter int STRIDE      = 1,
    parameter int MODE        = 0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          clk_en,
    input  logic                          in_valid,
    input  logic [D_CHANNELS*D_WIDTH-1:0] input_data,
    output logic [Q_CHANNELS*Q_WIDTH-1:0] output_data,
    output logic                          valid,
    output logic                          frame_done
);

    localparam int PW    = D_CHANNELS * D_WIDTH;
    localparam int CW    = clog2(IMAGE_SIZE);
    localparam int FN    = FILTER_SIZE * FILTER_SIZE * D_CHANNELS;
    localparam int MAXV  = FN * ((1 << D_WIDTH) - 1);
    localparam int SUM_W = clog2(MAXV + 1);
    localparam int EW    = (SUM_W > Q_WIDTH) ? SUM_W : Q_WIDTH;
    localparam int LAST  = FILTER_SIZE - 1
                         + ((IMAGE_SIZE - FILTER_SIZE) / STRIDE) * STRIDE;

    logic [CW-1:0] row, col, row_ph, col_ph;
    logic          acc, eol, eof, complete, at_last;

    logic [PW-1:0] col_in [FILTER_SIZE];
    logic [PW-1:0] lb_out [FILTER_SIZE-1];
    logic [PW-1:0] win    [FILTER_SIZE][FILTER_SIZE];

    logic [SUM_W-1:0]   res_sum, res, res_q;
    logic [D_WIDTH-1:0] res_max;
    logic [EW-1:0]      ext;
    logic [Q_WIDTH-1:0] sat;

    stage_t s1, s2;

    function automatic logic [CW-1:0] ph_step(input logic [CW-1:0] p);
        return (p == CW'(STRIDE - 1)) ? '0 : p + 1'b1;
    endfunction

    assign acc      = clk_en & in_valid;
    assign eol      = (col == CW'(IMAGE_SIZE - 1));
    assign eof      = eol && (row == CW'(IMAGE_SIZE - 1));
    assign at_last  = (row == CW'(LAST)) && (col == CW'(LAST));
    assign complete = (row >= CW'(FILTER_SIZE - 1))
                   && (col >= CW'(FILTER_SIZE - 1))
                   && (row_ph == '0) && (col_ph == '0);

    // Phase counters track (pos - FILTER_SIZE + 1) mod STRIDE without a divider
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row    <= '0;
            col    <= '0;
            row_ph <= '0;
            col_ph <= '0;
        end else if (acc) begin
            if (eol) begin
                col    <= '0;
                col_ph <= '0;
                row    <= eof ? '0 : row + 1'b1;
                row_ph <= (eof || row < CW'(FILTER_SIZE - 1))
                        ? '0 : ph_step(row_ph);
            end else begin
                col    <= col + 1'b1;
                col_ph <= (col < CW'(FILTER_SIZE - 1))
                        ? '0 : ph_step(col_ph);
            end
        end
    end

    assign col_in[FILTER_SIZE-1] = input_data;

    for (genvar k = 0; k < FILTER_SIZE - 1; k++) begin : g_lb
        logic [PW-1:0] lb_din;
        if (k == 0) begin : g_head
            assign lb_din = input_data;
        end else begin : g_chain
            assign lb_din = lb_out[k-1];
        end
        line_buffer #(
            .WIDTH (PW),
            .DEPTH (IMAGE_SIZE)
        ) u_lb (
            .clk      (clk),
            .shift_en (acc),
            .din      (lb_din),
            .dout     (lb_out[k])
        );
        assign col_in[FILTER_SIZE-2-k] = lb_out[k];
    end

    always_ff @(posedge clk) begin
        if (acc) begin
            for (int r = 0; r < FILTER_SIZE; r++) begin
                for (int c = 0; c < FILTER_SIZE - 1; c++) begin
                    win[r][c] <= win[r][c+1];
                end
                win[r][FILTER_SIZE-1] <= col_in[r];
            end
        end
    end

    always_comb begin
        logic [D_WIDTH-1:0] px;
        px      = '0;
        res_sum = '0;
        res_max = '0;
        for (int r = 0; r < FILTER_SIZE; r++) begin
            for (int c = 0; c < FILTER_SIZE; c++) begin
                for (int ch = 0; ch < D_CHANNELS; ch++) begin
                    px      = win[r][c][ch*D_WIDTH +: D_WIDTH];
                    res_sum = res_sum + SUM_W'(px);
                    if (px > res_max) res_max = px;
                end
            end
        end
    end

    always_comb begin
        case (MODE)
            MODE_SUM: res = res_sum;
            MODE_MAX: res = SUM_W'(res_max);
            default:  res = '0;
        endcase
    end

    assign ext = EW'(res_q);
    assign sat = (ext > EW'({Q_WIDTH{1'b1}})) ? '1 : ext[Q_WIDTH-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1          <= '0;
            s2          <= '0;
            res_q       <= '0;
            output_data <= '0;
            valid       <= 1'b0;
            frame_done  <= 1'b0;
        end else if (clk_en) begin
            s1 <= '{v:    in_valid & complete,
                    last: in_valid & complete & at_last};
            s2 <= s1;
            if (s1.v) res_q <= res;
            valid      <= s2.v;
            frame_done <= s2.last;
            if (s2.v) output_data <= {Q_CHANNELS{sat}};
        end
    end

endmodule

// File: tb/tb_strided_conv_layer.sv
// Bench for strided_conv_layer: four parameterisations share one stream.
// Expected values come from closed-form window results per position.
module tb_strided_conv_layer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clk_en;
    logic        in_valid;
    logic [15:0] in_def, in_s2, in_q10, in_max;
    logic [47:0] od_def, od_s2, od_max;
    logic [29:0] od_q10;
    logic [3:0]  vld, fdn;
    logic [47:0] od [4];

    always #5 clk = ~clk;

    strided_conv_layer u_def (
        .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .in_valid(in_valid),
        .input_data(in_def), .output_data(od_def),
        .valid(vld[0]), .frame_done(fdn[0]));

    strided_conv_layer #(.STRIDE(2)) u_s2 (
        .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .in_valid(in_valid),
        .input_data(in_s2), .output_data(od_s2),
        .valid(vld[1]), .frame_done(fdn[1]));

    strided_conv_layer #(.Q_WIDTH(10)) u_q10 (
        .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .in_valid(in_valid),
        .input_data(in_q10), .output_data(od_q10),
        .valid(vld[2]), .frame_done(fdn[2]));

    strided_conv_layer #(.MODE(1)) u_max (
        .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .in_valid(in_valid),
        .input_data(in_max), .output_data(od_max),
        .valid(vld[3]), .frame_done(fdn[3]));

    assign od[0] = od_def;
    assign od[1] = od_s2;
    assign od[2] = {18'd0, od_q10};
    assign od[3] = od_max;

    typedef struct {
        int d;
        int r;
        int c;
        int v;
    } vec_t;

    int checks = 0;
    int errors = 0;
    int brow, bcol, en_cnt, acc11, first_v;
    int pq [4][$];
    int vcnt [4];
    int fcnt [4];
    logic [47:0] cap  [4][4096];
    bit          seen [4][4096];
    logic [3:0]  pv;
    logic [47:0] pod [4];
    vec_t        tbl [10];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d t=%0t",
                     nm, act, exp, $time);
        end
    endtask

    function automatic bit complete(input int d, input int r, input int c);
        int s;
        s = (d == 1) ? 2 : 1;
        return r >= 1 && c >= 1 && ((r - 1) % s) == 0 && ((c - 1) % s) == 0;
    endfunction

    function automatic int expv(input int d, input int r, input int c);
        case (d)
            0:       return 12;
            1:       return 4 * (r + c) - 4;
            2:       return 1023;
            default: return r + c;
        endcase
    endfunction

    function automatic logic [47:0] pack(input int d, input int v);
        if (d == 2) return {18'd0, v[9:0], v[9:0], v[9:0]};
        return {v[15:0], v[15:0], v[15:0]};
    endfunction

    task automatic drive();
        logic [7:0] m;
        m      = 8'((brow + bcol) % 256);
        in_s2  = {bcol[7:0], brow[7:0]};
        in_max = {m, m};
    endtask

    task automatic clear_counts();
        for (int d = 0; d < 4; d++) begin
            vcnt[d] = 0;
            fcnt[d] = 0;
        end
    endtask

    task automatic step(input bit en, input bit iv);
        int p;
        clk_en   = en;
        in_valid = iv;
        drive();
        @(posedge clk);
        #1;
        if (en) en_cnt++;
        if (en && iv) begin
            for (int d = 0; d < 4; d++)
                if (complete(d, brow, bcol)) pq[d].push_back(brow * 64 + bcol);
            if (brow == 1 && bcol == 1) acc11 = en_cnt;
            if (bcol == 63) begin
                bcol = 0;
                brow = (brow == 63) ? 0 : brow + 1;
            end else begin
                bcol++;
            end
        end
        for (int d = 0; d < 4; d++) begin
            if (!en) begin
                chk("hold_valid", 64'(vld[d]), 64'(pv[d]));
                chk("hold_data", 64'(od[d]), 64'(pod[d]));
            end else if (vld[d]) begin
                if (pq[d].size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_valid dut=%0d actual=1 required=0", d);
                end else begin
                    p = pq[d].pop_front();
                    chk($sformatf("data_d%0d_r%0d_c%0d", d, p / 64, p % 64),
                        64'(od[d]), 64'(pack(d, expv(d, p / 64, p % 64))));
                    chk("frame_done_pos", 64'(fdn[d]), 64'(p == 4095));
                    cap[d][p]  = od[d];
                    seen[d][p] = 1'b1;
                    vcnt[d]++;
                    if (fdn[d]) fcnt[d]++;
                    if (d == 0 && first_v < 0) first_v = en_cnt;
                end
            end else begin
                chk("idle_data_hold", 64'(od[d]), 64'(pod[d]));
                chk("idle_frame_done", 64'(fdn[d]), 64'(0));
            end
        end
        pv = vld;
        for (int d = 0; d < 4; d++) pod[d] = od[d];
    endtask

    task automatic hold_reset();
        rst_n    = 1'b0;
        clk_en   = 1'b1;
        in_valid = 1'b1;
        #1;
        for (int d = 0; d < 4; d++) pq[d].delete();
        repeat (3) begin
            @(posedge clk);
            #1;
            for (int d = 0; d < 4; d++) begin
                chk("reset_valid", 64'(vld[d]), 64'(0));
                chk("reset_data", 64'(od[d]), 64'(0));
                chk("reset_frame_done", 64'(fdn[d]), 64'(0));
            end
        end
        rst_n   = 1'b1;
        brow    = 0;
        bcol    = 0;
        first_v = -1;
        acc11   = -1;
        pv      = '0;
        for (int d = 0; d < 4; d++) pod[d] = '0;
    endtask

    task automatic frame_checks(input int r_rows);
        int exp1;
        exp1 = (r_rows == 63) ? 1024 : (r_rows + 1) / 2 * 32;
        for (int d = 0; d < 4; d++) begin
            chk($sformatf("valid_count_d%0d", d), 64'(vcnt[d]),
                64'((d == 1) ? exp1 : r_rows * 63));
            chk($sformatf("pending_d%0d", d), 64'(pq[d].size()), 64'(0));
        end
    endtask

    initial begin
        int  acc_n;
        int  guard;
        bit  en, iv;

        tbl[0] = '{0, 1, 1, 12};
        tbl[1] = '{0, 63, 63, 12};
        tbl[2] = '{1, 1, 1, 4};
        tbl[3] = '{1, 3, 5, 28};
        tbl[4] = '{1, 63, 63, 500};
        tbl[5] = '{2, 1, 1, 1023};
        tbl[6] = '{2, 40, 7, 1023};
        tbl[7] = '{3, 1, 1, 2};
        tbl[8] = '{3, 63, 63, 126};
        tbl[9] = '{3, 10, 20, 30};

        in_def = {8'd1, 8'd2};
        in_q10 = 16'hFFFF;
        brow   = 0;
        bcol   = 0;
        en_cnt = 0;
        drive();
        hold_reset();

        clear_counts();
        repeat (4096) step(1'b1, 1'b1);
        repeat (4) step(1'b1, 1'b0);
        frame_checks(63);
        for (int d = 0; d < 4; d++)
            chk($sformatf("frames_d%0d", d), 64'(fcnt[d]), 64'(1));
        chk("first_latency", 64'(first_v - acc11), 64'(2));

        for (int i = 0; i < 10; i++) begin
            chk($sformatf("tbl%0d_seen", i),
                64'(seen[tbl[i].d][tbl[i].r * 64 + tbl[i].c]), 64'(1));
            chk($sformatf("tbl%0d_value", i),
                64'(cap[tbl[i].d][tbl[i].r * 64 + tbl[i].c]),
                64'(pack(tbl[i].d, tbl[i].v)));
        end

        clear_counts();
        acc_n = 0;
        guard = 0;
        while (acc_n < 4096 && guard < 40000) begin
            en = ($urandom_range(0, 3) != 0);
            iv = ($urandom_range(0, 3) != 0);
            step(en, iv);
            if (en && iv) acc_n++;
            guard++;
        end
        chk("gap_frame_complete", 64'(acc_n), 64'(4096));
        repeat (4) step(1'b1, 1'b0);
        frame_checks(63);
        for (int d = 0; d < 4; d++)
            chk($sformatf("gap_frames_d%0d", d), 64'(fcnt[d]), 64'(1));

        while (brow * 64 + bcol <= 100) step(1'b1, 1'b1);
        hold_reset();
        clear_counts();
        repeat (256) step(1'b1, 1'b1);
        repeat (4) step(1'b1, 1'b0);
        frame_checks(3);
        chk("reset_latency", 64'(first_v - acc11), 64'(2));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/strided_conv_layer.md
STRIDED_CONV_LAYER -- requirements
Module: strided_conv_layer

Interface
REQ-001 SHALL have parameter D_WIDTH, default 8: unsigned input pixel width per channel.
REQ-002 SHALL have parameter Q_WIDTH, default 16: unsigned output width per channel.
REQ-003 SHALL have parameter D_CHANNELS, default 2: input channel count.
REQ-004 SHALL have parameter Q_CHANNELS, default 3: output channel count.
REQ-005 SHALL have parameter FILTER_SIZE, default 2: square window side, range 2..8.
REQ-006 SHALL have parameter IMAGE_SIZE, default 64: square frame side in pixels, greater than FILTER_SIZE.
REQ-007 SHALL have parameter STRIDE, default 1: window step in rows and columns, range 1..FILTER_SIZE.
REQ-008 SHALL have parameter MODE, default 0: 0 = window sum, 1 = window max.
REQ-009 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-010 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-011 SHALL have port clk_en, input, 1 bit: pipeline advances only when high.
REQ-012 SHALL have port in_valid, input, 1 bit: input_data carries a pixel this cycle.
REQ-013 SHALL have port input_data, input, D_CHANNELS*D_WIDTH bits: channel 0 in the MSBs.
REQ-014 SHALL have port output_data, output, Q_CHANNELS*Q_WIDTH bits: channel 0 in the LSBs.
REQ-015 SHALL have port valid, output, 1 bit: one-cycle pulse qualifying output_data.
REQ-016 SHALL have port frame_done, output, 1 bit: one-cycle pulse with the last output of a frame.

Function
REQ-017 SHALL accept a pixel on a rising edge only when clk_en=1 and in_valid=1; pixels arrive in raster order, row-major.
REQ-018 SHALL keep column and row counters 0..IMAGE_SIZE-1; after (IMAGE_SIZE-1, IMAGE_SIZE-1) both SHALL wrap to 0 (next frame).
REQ-019 SHALL keep FILTER_SIZE-1 line buffers of IMAGE_SIZE pixels plus a FILTER_SIZE x FILTER_SIZE window register, written only on accept.
REQ-020 SHALL declare a window complete when the accepted pixel has row >= FILTER_SIZE-1, col >= FILTER_SIZE-1, (row-FILTER_SIZE+1) mod STRIDE = 0 and (col-FILTER_SIZE+1) mod STRIDE = 0; windows never span a row or frame boundary.
REQ-021 MODE=0: every output channel SHALL be the unsigned sum over all window positions and all input channels, saturated to 2^Q_WIDTH-1.
REQ-022 MODE=1: every output channel SHALL be the maximum over all window positions and input channels, zero-extended to Q_WIDTH.
REQ-023 SHALL compute the internal sum at full width (clog2 of FILTER_SIZE^2*D_CHANNELS*(2^D_WIDTH-1), rounded up) before saturation.
REQ-024 Latency SHALL be exactly 2 enabled cycles: valid rises at the second clk_en=1 edge after the accepting edge.
REQ-025 When clk_en=0 all state, output_data and valid SHALL hold; valid SHALL be cleared on the next enabled edge with no new result.
REQ-026 in_valid=0 with clk_en=1 SHALL insert a bubble: no counter or buffer change; results in flight still emerge.
REQ-027 output_data SHALL hold its last value while valid=0.
REQ-028 frame_done SHALL assert in the same cycle as the valid for the window ending at (IMAGE_SIZE-1, IMAGE_SIZE-1), when that window is complete per REQ-020; otherwise with the last complete window of the frame.
REQ-029 A new frame's first pixel SHALL be accepted the cycle after the previous frame's last, without a gap.

Reset
REQ-030 rst_n=0 SHALL asynchronously clear counters, pipeline registers, output_data, valid and frame_done to 0.
REQ-031 Line buffer and window contents need not be cleared; REQ-020 prevents stale data reaching an output.
REQ-032 Reset mid-frame SHALL drop all results in flight; the next accepted pixel is (0,0).

Structure
REQ-033 MODE_SUM/MODE_MAX constants and the clog2 function SHALL live in the common definitions file.
REQ-034 SHALL instantiate one sub-module, line_buffer (parameters WIDTH and DEPTH, shift-enable input), once per buffered row.

Verification
REQ-035 Defaults, ch0=1, ch1=2 for every pixel: every output channel = 12; 3969 valids per frame; first valid 2 cycles after accepting pixel (1,1).
REQ-036 STRIDE=2, counter-pattern frame: exactly 1024 valids; first output = sum of pixels (0,0),(0,1),(1,0),(1,1).
REQ-037 Q_WIDTH=10, all inputs 255: raw sum 2040 -> every output channel = 1023.
REQ-038 MODE=1, pixel value = (row+col) mod 256 in both channels: output at window (1,1) = 2; at window (63,63) = 126.
REQ-039 Random in_valid and clk_en low gaps: output sequence identical to the gap-free run; valid never high during clk_en=0 cycles; frame_done once per frame.
REQ-040 rst_n low at accepted pixel 100, then a new frame: no valid until 2 cycles after new pixel (1,1); all outputs 0 during reset.
